// File: rtl/tlb_pkg.sv
// Shared types for the TLB refill path: refill FSM states, requester ids and
// the beat-counter width helper.
package tlb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FINISH
  } refill_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_ITLB = 1'b0;
  localparam req_id_t REQ_DTLB = 1'b1;

  // Width of the beat counter that walks one line of bank_num beats.
  function automatic int beat_cnt_w(input int bank_num);
    return $clog2(bank_num);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The last-grant register advances only when the
// owner strobes en_i, so the grant is stable while a refill is in flight.
module rr_arbiter2
  import tlb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_valid_o,
  output req_id_t    gnt_id_o
);

  req_id_t last_q;

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = REQ_ITLB;
    if (req_i == 2'b11) begin
      gnt_id_o = ~last_q;
    end else if (req_i[1]) begin
      gnt_id_o = REQ_DTLB;
    end
  end

  // NOTE: reset is synchronous here, so rstn sits inside the clocked branch
  // rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= REQ_DTLB;
    end else if (en_i && gnt_valid_o) begin
      last_q <= gnt_id_o;
    end
  end

endmodule

// File: rtl/tlb_refill_arbiter.sv
// Serves ITLB/DTLB line refills from a single-outstanding memory port, one
// requester at a time, writing each returned beat into the owning bank.
module tlb_refill_arbiter
  import tlb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            miss,
  input  logic [ADDR_WIDTH-1:0] miss_addr0,
  input  logic [ADDR_WIDTH-1:0] miss_addr1,
  input  logic [1:0]            miss_set,
  output logic [1:0]            busy_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic [1:0]            wen_rd,
  output logic                  set_rd,
  output logic [1:0]            finish_rd,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int               CNT_W     = beat_cnt_w(BANK_NUM);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BANK_NUM - 1);

  refill_state_e         state_q;
  req_id_t               owner_q;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  set_q;
  logic                  gnt_valid;
  req_id_t               gnt_id;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [1:0]            owner_mask;
  logic                  beat_wr;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .req_i       (miss),
    .en_i        (state_q == ST_IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_comb begin
    base_d            = (gnt_id == REQ_DTLB) ? miss_addr1 : miss_addr0;
    base_d[CNT_W-1:0] = '0;
    cnt_d             = cnt_q + CNT_W'(1);
  end

  // The counter wraps to zero after the last beat, so base|count also yields
  // the line base during FINISH.
  assign beat_addr  = {base_q[ADDR_WIDTH-1:CNT_W], cnt_q};
  assign owner_mask = {owner_q, ~owner_q};
  assign beat_wr    = rstn && (state_q == ST_WAIT) && mem_rvalid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_ITLB;
      base_q  <= '0;
      cnt_q   <= '0;
      set_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt_id;
            base_q  <= base_d;
            set_q   <= miss_set[gnt_id];
            cnt_q   <= '0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            cnt_q   <= cnt_d;
            state_q <= (cnt_q == LAST_BEAT) ? ST_FINISH : ST_REQ;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_rd   = {2{state_q != ST_IDLE}};
  assign mem_ren   = (state_q == ST_REQ);
  assign mem_addr  = beat_addr;
  assign addr_rd   = beat_addr;
  assign data_rd   = beat_wr ? mem_rdata : '0;
  assign wen_rd    = beat_wr ? owner_mask : 2'b00;
  assign finish_rd = (state_q == ST_FINISH) ? owner_mask : 2'b00;
  assign set_rd    = set_q;

endmodule

// File: doc/tlb_refill_arbiter.md
TLB_REFILL_ARBITER -- requirements
Module: tlb_refill_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, is the word-granular address width shared with the TLB banks.
REQ-002 Parameter DATA_WIDTH, default 64, is the beat width.
REQ-003 Parameter BANK_NUM, default 4, is the number of beats per line (power of two, >=2).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 miss  input  2  per-requester refill request (bank miss_cache); index 0 = ITLB, 1 = DTLB.
REQ-007 miss_addr0, miss_addr1  input  ADDR_WIDTH each  line base address (bank addr_cache) per requester.
REQ-008 miss_set  input  2  victim way per requester (bank set_cache).
REQ-009 busy_rd  output  2  per-requester busy; blocks further miss_cache.
REQ-010 addr_rd  output  ADDR_WIDTH  beat address broadcast to both banks.
REQ-011 data_rd  output  DATA_WIDTH  beat data broadcast to both banks.
REQ-012 wen_rd  output  2  per-requester beat write enable.
REQ-013 set_rd  output  1  latched victim way.
REQ-014 finish_rd  output  2  per-requester one-cycle refill-complete pulse.
REQ-015 mem_ren  output  1  memory read request.
REQ-016 mem_addr  output  ADDR_WIDTH  memory beat address.
REQ-017 mem_ready  input  1  memory accepts request when mem_ren & mem_ready.
REQ-018 mem_rvalid  input  1  response beat valid.
REQ-019 mem_rdata  input  DATA_WIDTH  response beat data.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, FINISH.
REQ-021 In IDLE, if any miss bit is high, a grant SHALL be issued that cycle and the FSM SHALL move to REQ next cycle; otherwise stay IDLE.
REQ-022 Arbitration SHALL be round-robin: on simultaneous misses the requester not granted last wins; a single miss wins unconditionally; last-grant resets to 1 (so ITLB wins the first tie).
REQ-023 On grant, owner id, miss_addr of owner (low log2(BANK_NUM) bits forced 0) and miss_set of owner SHALL be latched; beat counter cleared.
REQ-024 busy_rd SHALL be 2'b11 in every state except IDLE, 2'b00 in IDLE.
REQ-025 In REQ, mem_ren=1 and mem_addr=latched base | beat counter; on mem_ready go to WAIT, else hold REQ with mem_addr stable.
REQ-026 In WAIT, mem_ren=0; on mem_rvalid: addr_rd=base|counter, data_rd=mem_rdata, wen_rd[owner]=1 for exactly that cycle, counter increments.
REQ-027 After the beat with counter==BANK_NUM-1 go to FINISH; otherwise return to REQ; one outstanding request at a time.
REQ-028 mem_rvalid outside WAIT SHALL be ignored (no wen_rd).
REQ-029 FINISH SHALL last one cycle: finish_rd[owner]=1, addr_rd=base, set_rd held, then IDLE.
REQ-030 set_rd SHALL equal the latched way from grant through FINISH.
REQ-031 The arbiter SHALL NOT sample miss outside IDLE; a loser's miss is served on a later IDLE.
REQ-032 Beat counter width SHALL be log2(BANK_NUM) and wrap to 0 after the last beat.

Reset
REQ-033 While rstn=0: state IDLE, last-grant=1, counter 0, all latches 0; busy_rd, wen_rd, finish_rd, mem_ren = 0; addr_rd, data_rd, mem_addr, set_rd = 0.
REQ-034 Reset asserted mid-refill SHALL abort without finish_rd or further wen_rd; responses arriving after reset release SHALL be ignored.

Structure
REQ-035 FSM state enum, requester-id type and beat-count width SHALL live in the shared package tlb_pkg.
REQ-036 Arbitration SHALL be a sub-module rr_arbiter2 (2-way round-robin, grant + last-grant register); the FSM remains in tlb_refill_arbiter.

Verification
REQ-037 miss=01, addr0=0x100, set0=1, mem_ready=1, rvalid one cycle after each request with data 0xA0..0xA3 -> four wen_rd=01 beats at addr_rd 0x100..0x103, set_rd=1, finish_rd=01 once, busy_rd high until IDLE.
REQ-038 miss=11 from reset -> ITLB refilled first, then DTLB; next simultaneous miss -> ITLB again (alternation holds).
REQ-039 mem_ready low 3 cycles in REQ -> mem_ren and mem_addr held stable, no wen_rd, beat order unchanged.
REQ-040 Spurious mem_rvalid in IDLE and in REQ -> no wen_rd, counter unchanged.
REQ-041 rstn=0 after second beat -> outputs zero next cycle, no finish_rd; fresh miss=10 then completes a full 4-beat refill normally.
